// File: rtl/tile_loader_if.sv
// Bus bundle between a tile_loader and its surroundings.
//   Config/control : start, rows, cols, base_row, base_col; busy, done, err back.
//   Global BRAM    : gb_rd_en, gb_addr out of the loader; gb_data back, one cycle later.
//   Tile BRAM bank : tile_wr_en (one-hot per tile), tile_addr, tile_data.
// master = the side that starts loads and owns the memories; slave = the loader.
interface tile_loader_if #(
  parameter int unsigned TILE_SIZE  = 4,
  parameter int unsigned GRID       = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18
);
  logic                                    start;
  logic [9:0]                              rows;
  logic [9:0]                              cols;
  logic [9:0]                              base_row;
  logic [9:0]                              base_col;
  logic                                    gb_rd_en;
  logic [ADDR_WIDTH-1:0]                   gb_addr;
  logic [DATA_WIDTH-1:0]                   gb_data;
  logic [GRID*GRID-1:0]                    tile_wr_en;
  logic [$clog2(TILE_SIZE*TILE_SIZE)-1:0]  tile_addr;
  logic [DATA_WIDTH-1:0]                   tile_data;
  logic                                    busy;
  logic                                    done;
  logic                                    err;

  modport master (
    output start, rows, cols, base_row, base_col, gb_data,
    input  gb_rd_en, gb_addr, tile_wr_en, tile_addr, tile_data, busy, done, err
  );

  modport slave (
    input  start, rows, cols, base_row, base_col, gb_data,
    output gb_rd_en, gb_addr, tile_wr_en, tile_addr, tile_data, busy, done, err
  );
endinterface

// File: rtl/tile_loader.sv
// Fetches one GRID x GRID block of TILE_SIZE x TILE_SIZE tiles from a row-major matrix
// in global BRAM and scatters it into GRID*GRID tile BRAMs, zero-padding elements that
// fall outside the matrix.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - tile_loader_if.slave: start/config in, global BRAM read port, tile BRAM write
//          port, busy/done/err status out
// TILE_SIZE and GRID must be powers of two (>= 2); interface parameters must match.
module tile_loader #(
  parameter int unsigned TILE_SIZE  = 4,
  parameter int unsigned GRID       = 4,
  parameter int unsigned MAX_SIZE   = 512,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18
) (
  input logic         clk,
  input logic         rst,
  tile_loader_if.slave bus
);

  localparam int unsigned Blk = GRID * TILE_SIZE;
  localparam int unsigned Cw  = $clog2(Blk);
  localparam int unsigned Tw  = $clog2(TILE_SIZE);
  localparam int unsigned Gw  = $clog2(GRID);
  localparam int unsigned Nt  = GRID * GRID;
  localparam logic [10:0] MaxSize = 11'(MAX_SIZE);
  localparam logic [Cw-1:0] IdxLast = Cw'(Blk - 1);

  typedef enum logic [2:0] {StIdle, StCheck, StRead, StDrain, StFin} state_e;

  state_e          state_q, state_d;
  logic [9:0]      rows_q, cols_q, base_row_q, base_col_q;
  logic [Cw-1:0]   r_q, r_d, c_q, c_d;
  logic            err_q, err_d;
  logic            accept;

  // Write stage: element info delayed one cycle to line up with gb_data.
  logic            wr_valid_q;
  logic            pad_q;
  logic [2*Gw-1:0] wr_tile_q;
  logic [2*Tw-1:0] wr_addr_q;

  logic [10:0]           gr, gc;
  logic                  in_bounds;
  logic                  cfg_bad;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // 11-bit sums so base+offset never wraps past the 10-bit bounds.
  assign gr        = {1'b0, base_row_q} + 11'(r_q);
  assign gc        = {1'b0, base_col_q} + 11'(c_q);
  assign in_bounds = (gr < {1'b0, rows_q}) && (gc < {1'b0, cols_q});
  assign rd_addr   = ADDR_WIDTH'(gr) * ADDR_WIDTH'(cols_q) + ADDR_WIDTH'(gc);
  assign cfg_bad   = (rows_q == 10'd0) || (cols_q == 10'd0) ||
                     ({1'b0, rows_q} > MaxSize) || ({1'b0, cols_q} > MaxSize);

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    c_d          = c_q;
    err_d        = err_q;
    accept       = 1'b0;
    bus.gb_rd_en = 1'b0;
    bus.gb_addr  = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          accept  = 1'b1;
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        bus.busy = 1'b1;
        r_d      = '0;
        c_d      = '0;
        if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          state_d = StRead;
        end
      end
      StRead: begin
        bus.busy     = 1'b1;
        bus.gb_rd_en = in_bounds;
        bus.gb_addr  = in_bounds ? rd_addr : '0;
        if (c_q == IdxLast) begin
          c_d = '0;
          r_d = r_q + 1'b1;
          if (r_q == IdxLast) begin
            r_d     = '0;
            state_d = StDrain;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      StDrain: begin
        bus.busy = 1'b1;
        state_d  = StFin;
      end
      StFin: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rows_q     <= '0;
      cols_q     <= '0;
      base_row_q <= '0;
      base_col_q <= '0;
      r_q        <= '0;
      c_q        <= '0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      pad_q      <= 1'b0;
      wr_tile_q  <= '0;
      wr_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      err_q   <= err_d;
      if (accept) begin
        rows_q     <= bus.rows;
        cols_q     <= bus.cols;
        // Block origin is always tile-aligned.
        base_row_q <= {bus.base_row[9:Tw], {Tw{1'b0}}};
        base_col_q <= {bus.base_col[9:Tw], {Tw{1'b0}}};
      end
      wr_valid_q <= (state_q == StRead);
      pad_q      <= ~in_bounds;
      wr_tile_q  <= {r_q[Cw-1:Tw], c_q[Cw-1:Tw]};
      wr_addr_q  <= {r_q[Tw-1:0], c_q[Tw-1:0]};
    end
  end

  assign bus.tile_wr_en = wr_valid_q ? (Nt'(1) << wr_tile_q) : '0;
  assign bus.tile_addr  = wr_valid_q ? wr_addr_q : '0;
  assign bus.tile_data  = (wr_valid_q && !pad_q) ? bus.gb_data : '0;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_tile_loader.sv
module tb_tile_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tile_loader_if #(.TILE_SIZE(4), .GRID(4), .DATA_WIDTH(32), .ADDR_WIDTH(18)) bus ();

  tile_loader #(
    .TILE_SIZE(4), .GRID(4), .MAX_SIZE(512), .DATA_WIDTH(32), .ADDR_WIDTH(18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Global BRAM model: word k holds value k, one-cycle read latency.
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.gb_data <= 32'd0;
    else if (bus.gb_rd_en) bus.gb_data <= 32'(bus.gb_addr);
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] tiles [16][16];
  int   done_cyc, rd_cnt, wr_cnt, first_addr, last_addr, bad_onehot, busy_bad;
  logic err_at_done;

  // Expected content of tile t, address a for a block load of word-k-holds-k data.
  function automatic logic [31:0] exp_val(int r, int c, int br, int bc, int t, int a);
    int gr, gc;
    gr = (br & ~3) + (t / 4) * 4 + a / 4;
    gc = (bc & ~3) + (t % 4) * 4 + a % 4;
    return (gr < r && gc < c) ? 32'(gr * c + gc) : 32'd0;
  endfunction

  // Starts a load at cycle 0 and records outputs every cycle until done or timeout.
  // Extra start pulses are driven at cycles p1/p2 (0 = none); config is scrambled
  // after acceptance to show it was latched.
  task automatic run_load(input logic [9:0] r, input logic [9:0] c, input logic [9:0] br,
                          input logic [9:0] bc, input int p1, input int p2);
    for (int t = 0; t < 16; t++)
      for (int a = 0; a < 16; a++) tiles[t][a] = 32'hDEAD_BEEF;
    done_cyc = -1; rd_cnt = 0; wr_cnt = 0; first_addr = -1; last_addr = -1;
    bad_onehot = 0; busy_bad = 0; err_at_done = 1'bx;
    @(negedge clk);
    bus.rows = r; bus.cols = c; bus.base_row = br; bus.base_col = bc; bus.start = 1'b1;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == p1) || (cyc == p2);
      if (cyc == 1) begin
        bus.rows = 10'd3; bus.cols = 10'd5; bus.base_row = 10'd40; bus.base_col = 10'd8;
      end
      if (bus.gb_rd_en) begin
        rd_cnt++;
        if (first_addr < 0) first_addr = int'(bus.gb_addr);
        last_addr = int'(bus.gb_addr);
      end
      if (|bus.tile_wr_en) begin
        wr_cnt++;
        if (!$onehot(bus.tile_wr_en)) bad_onehot++;
        else for (int t = 0; t < 16; t++)
          if (bus.tile_wr_en[t]) tiles[t][bus.tile_addr] = bus.tile_data;
      end
      if (bus.done) begin
        done_cyc = cyc;
        err_at_done = bus.err;
        if (bus.busy) busy_bad++;
      end else if (!bus.busy) begin
        busy_bad++;
      end
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL timeout: no done within 400 cycles (rows=%0d cols=%0d)", r, c);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({bus.gb_rd_en, bus.busy, bus.done, bus.err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rd/busy/done/err=%b required 0000",
               {bus.gb_rd_en, bus.busy, bus.done, bus.err});
    end
    checks++;
    if (bus.tile_wr_en !== 16'd0 || bus.gb_addr !== 18'd0 || bus.tile_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: wr_en=%h gb_addr=%0d tile_data=%0d required all 0",
               bus.tile_wr_en, bus.gb_addr, bus.tile_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_full_16;
    run_load(10'd16, 10'd16, 10'd0, 10'd0, 0, 0);
    checks++;
    if (done_cyc !== 259) begin
      errors++; $display("FAIL full_done_cycle: got %0d required 259", done_cyc);
    end
    checks++;
    if (err_at_done !== 1'b0) begin
      errors++; $display("FAIL full_err: got %b required 0", err_at_done);
    end
    checks++;
    if (wr_cnt !== 256 || rd_cnt !== 256 || bad_onehot !== 0) begin
      errors++;
      $display("FAIL full_counts: wr=%0d rd=%0d bad_onehot=%0d required 256 256 0",
               wr_cnt, rd_cnt, bad_onehot);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++; $display("FAIL full_busy: %0d bad busy cycles required 0", busy_bad);
    end
    // Tile 0: 0,1,2,3,16,17,18,19,32..35,48..51
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (tiles[0][a] !== 32'((a / 4) * 16 + a % 4)) begin
        errors++;
        $display("FAIL full_tile0[%0d]: got %0d required %0d", a, tiles[0][a],
                 (a / 4) * 16 + a % 4);
      end
    end
    checks++;
    if (tiles[5][0] !== 32'd68) begin
      errors++; $display("FAIL full_tile5[0]: got %0d required 68", tiles[5][0]);
    end
    for (int t = 0; t < 16; t++)
      for (int a = 0; a < 16; a++) begin
        checks++;
        if (tiles[t][a] !== exp_val(16, 16, 0, 0, t, a)) begin
          errors++;
          $display("FAIL full_tile[%0d][%0d]: got %0d required %0d", t, a, tiles[t][a],
                   exp_val(16, 16, 0, 0, t, a));
        end
      end
  endtask

  task automatic test_small_8;
    run_load(10'd8, 10'd8, 10'd0, 10'd0, 0, 0);
    checks++;
    if (rd_cnt !== 64 || wr_cnt !== 256) begin
      errors++; $display("FAIL small_counts: rd=%0d wr=%0d required 64 256", rd_cnt, wr_cnt);
    end
    checks++;
    if (done_cyc !== 259 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL small_done: cycle=%0d err=%b required 259 0", done_cyc, err_at_done);
    end
    for (int t = 0; t < 16; t++)
      for (int a = 0; a < 16; a++) begin
        checks++;
        if (tiles[t][a] !== exp_val(8, 8, 0, 0, t, a)) begin
          errors++;
          $display("FAIL small_tile[%0d][%0d]: got %0d required %0d", t, a, tiles[t][a],
                   exp_val(8, 8, 0, 0, t, a));
        end
      end
  endtask

  task automatic test_offset_32(input logic [9:0] br, input logic [9:0] bc);
    run_load(10'd32, 10'd32, br, bc, 0, 0);
    checks++;
    if (first_addr !== 528 || last_addr !== 1023) begin
      errors++;
      $display("FAIL offset_addr(%0d,%0d): first=%0d last=%0d required 528 1023",
               br, bc, first_addr, last_addr);
    end
    checks++;
    if (tiles[15][15] !== 32'd1023) begin
      errors++; $display("FAIL offset_tile15[15]: got %0d required 1023", tiles[15][15]);
    end
    checks++;
    if (done_cyc !== 259) begin
      errors++; $display("FAIL offset_done_cycle: got %0d required 259", done_cyc);
    end
    for (int t = 0; t < 16; t++)
      for (int a = 0; a < 16; a++) begin
        checks++;
        if (tiles[t][a] !== exp_val(32, 32, 16, 16, t, a)) begin
          errors++;
          $display("FAIL offset_tile[%0d][%0d]: got %0d required %0d", t, a, tiles[t][a],
                   exp_val(32, 32, 16, 16, t, a));
        end
      end
  endtask

  task automatic test_outside;
    run_load(10'd16, 10'd16, 10'd32, 10'd0, 0, 0);
    checks++;
    if (rd_cnt !== 0 || wr_cnt !== 256 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL outside: rd=%0d wr=%0d err=%b required 0 256 0",
               rd_cnt, wr_cnt, err_at_done);
    end
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (tiles[t][0] !== 32'd0 || tiles[t][15] !== 32'd0) begin
        errors++;
        $display("FAIL outside_tile%0d: got %0d,%0d required 0,0", t, tiles[t][0],
                 tiles[t][15]);
      end
    end
  endtask

  task automatic test_start_ignored;
    run_load(10'd16, 10'd16, 10'd0, 10'd0, 50, 259);
    checks++;
    if (done_cyc !== 259 || tiles[5][0] !== 32'd68) begin
      errors++;
      $display("FAIL restart_ignored: done=%0d tile5[0]=%0d required 259 68",
               done_cyc, tiles[5][0]);
    end
    // Start held into cycle 260 must be accepted there.
    run_load(10'd16, 10'd16, 10'd0, 10'd0, 0, 0);
    checks++;
    if (done_cyc !== 259 || wr_cnt !== 256) begin
      errors++;
      $display("FAIL accept_after_fin: done=%0d wr=%0d required 259 256", done_cyc, wr_cnt);
    end
  endtask

  task automatic test_error;
    run_load(10'd16, 10'd0, 10'd0, 10'd0, 0, 0);
    checks++;
    if (done_cyc !== 2 || err_at_done !== 1'b1) begin
      errors++;
      $display("FAIL err_cols0: done=%0d err=%b required 2 1", done_cyc, err_at_done);
    end
    checks++;
    if (wr_cnt !== 0 || rd_cnt !== 0) begin
      errors++; $display("FAIL err_no_writes: wr=%0d rd=%0d required 0 0", wr_cnt, rd_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL err_hold: err=%b done=%b required 1 0", bus.err, bus.done);
    end
    run_load(10'd600, 10'd16, 10'd0, 10'd0, 0, 0);
    checks++;
    if (done_cyc !== 2 || err_at_done !== 1'b1 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL err_rows_big: done=%0d err=%b wr=%0d required 2 1 0",
               done_cyc, err_at_done, wr_cnt);
    end
    run_load(10'd16, 10'd16, 10'd0, 10'd0, 0, 0);
    checks++;
    if (err_at_done !== 1'b0 || done_cyc !== 259) begin
      errors++;
      $display("FAIL err_clear: err=%b done=%0d required 0 259", err_at_done, done_cyc);
    end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    bus.rows = 10'd16; bus.cols = 10'd16; bus.base_row = 10'd0; bus.base_col = 10'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 2; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.gb_rd_en, bus.busy, bus.done, bus.err} !== 4'b0 || bus.tile_wr_en !== 16'd0 ||
        bus.gb_addr !== 18'd0 || bus.tile_data !== 32'd0 || bus.tile_addr !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rd/busy/done/err=%b wr_en=%h addr=%0d required 0",
               {bus.gb_rd_en, bus.busy, bus.done, bus.err}, bus.tile_wr_en, bus.gb_addr);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    rst = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++; $display("FAIL mid_reset_no_done: %0d done pulses required 0", seen_done);
    end
    run_load(10'd16, 10'd16, 10'd0, 10'd0, 0, 0);
    checks++;
    if (done_cyc !== 259 || err_at_done !== 1'b0 || wr_cnt !== 256) begin
      errors++;
      $display("FAIL after_reset_load: done=%0d err=%b wr=%0d required 259 0 256",
               done_cyc, err_at_done, wr_cnt);
    end
    for (int t = 0; t < 16; t++)
      for (int a = 0; a < 16; a++) begin
        checks++;
        if (tiles[t][a] !== exp_val(16, 16, 0, 0, t, a)) begin
          errors++;
          $display("FAIL after_reset_tile[%0d][%0d]: got %0d required %0d", t, a,
                   tiles[t][a], exp_val(16, 16, 0, 0, t, a));
        end
      end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.rows = 10'd0; bus.cols = 10'd0; bus.base_row = 10'd0; bus.base_col = 10'd0;
    test_reset;
    test_full_16;
    test_small_8;
    test_offset_32(10'd16, 10'd16);
    test_offset_32(10'd19, 10'd18);
    test_outside;
    test_start_ignored;
    test_error;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_loader.md
Name: tile_loader

Overview:
Fetch engine between global_bram and the 16-entry tiled_bram bank (input or weight side; the top level steers the write bus to one bank).
- On start, reads one GRID x GRID block of TILE_SIZE x TILE_SIZE tiles (default 16x16 elements) from a row-major matrix in global BRAM.
- Scatters the elements into the per-tile BRAMs.
- Zero-pads any element outside the matrix bounds.

Parameters:
- TILE_SIZE, 4, tile edge in elements.
- GRID, 4, tiles per block edge; number of tile BRAMs = GRID*GRID.
- MAX_SIZE, 512, largest legal rows/cols.
- DATA_WIDTH, 32, element width.
- ADDR_WIDTH, 18, global BRAM address width; must be at least log2(MAX_SIZE*MAX_SIZE).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- rows  in  10  matrix row count, 1..MAX_SIZE.
- cols  in  10  matrix column count (row stride), 1..MAX_SIZE.
- base_row  in  10  block origin row; low log2(TILE_SIZE) bits forced to 0.
- base_col  in  10  block origin column; low log2(TILE_SIZE) bits forced to 0.
- gb_rd_en  out  1  global BRAM read strobe.
- gb_addr  out  ADDR_WIDTH  global BRAM read address.
- gb_data  in  DATA_WIDTH  global BRAM read data; valid 1 cycle after gb_rd_en.
- tile_wr_en  out  GRID*GRID  one-hot write enable, bit t selects tile BRAM t.
- tile_addr  out  log2(TILE_SIZE^2)  element address inside the tile.
- tile_data  out  DATA_WIDTH  element written.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 means the configuration was rejected.

Behaviour:
- Reset (rst=0, async): FSM to IDLE, all counters 0, every output 0.
- Inputs rows/cols/base_row/base_col are latched on the start-accept edge. Later changes have no effect until the next start.
- FSM states: IDLE, CHECK, READ, DRAIN, FIN.
- IDLE: start=1 latches the config and goes to CHECK (busy=1 from the next cycle).
- CHECK (1 cycle): if rows==0, cols==0, rows>MAX_SIZE or cols>MAX_SIZE, go to FIN with err=1 and no writes. Otherwise go to READ with r=c=0.
- READ:
  - Each cycle handles element (r,c) of the block; c is the fast index; r,c run 0..GRID*TILE_SIZE-1.
  - gr = base_row+r, gc = base_col+c.
  - In bounds (gr<rows and gc<cols): gb_rd_en=1, gb_addr = gr*cols+gc, computed at full ADDR_WIDTH with no truncation.
  - Out of bounds: gb_rd_en=0 and the element is marked pad.
  - After the last element (r=c=GRID*TILE_SIZE-1), go to DRAIN.
- Write stage (every element, one cycle after its READ cycle):
  - tile_wr_en bit = (r/TILE_SIZE)*GRID + (c/TILE_SIZE).
  - tile_addr = (r%TILE_SIZE)*TILE_SIZE + (c%TILE_SIZE).
  - tile_data = gb_data, or 0 if pad.
  - Exactly one tile_wr_en bit is high per written element; all bits are 0 otherwise.
- DRAIN: 1 cycle, completes the final write, then FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, err as decided; then IDLE.
- Latency, with the start-accept edge as cycle 0:
  - CHECK at cycle 1.
  - First read at cycle 2, first write at cycle 3.
  - Last write at cycle 258 (256 elements at defaults).
  - done at cycle 259.
- Error path: done at cycle 2, err=1, zero tile writes.
- A block fully outside the matrix is not an error: all 256 writes are zero, err=0.
- start while busy is ignored; no queuing.
- start in the same cycle as done/FIN is ignored. It is accepted on the next cycle in IDLE.
- Reset asserted mid-load aborts immediately: no done pulse, and tile contents are left partially written.
- err holds its value until the next start acceptance; done is a pulse only.

Test Plan:
- rows=cols=16, base=(0,0), global word k holds value k:
  - Tile 0 addr 0..15 receives 0,1,2,3,16,17,18,19,32,...,51.
  - Tile 5 addr 0 receives 68.
  - done at cycle 259, err=0.
- rows=cols=8, base=(0,0):
  - Tiles 0,1,4,5 hold matrix data.
  - Tiles 2,3,6..15 are all zeros.
  - gb_rd_en is high for exactly 64 cycles; 256 writes total.
- rows=cols=32, base=(16,16):
  - First gb_addr = 528, last gb_addr = 1023.
  - Tile 15 addr 15 receives the value at address 1023.
- Start pulsed again at cycles 50 and 259 during a 16x16 load: both ignored, single done. A start at cycle 260 is accepted.
- cols=0: done at cycle 2 with err=1, no tile_wr_en activity. Then a valid start clears err at completion.
- rst driven low at cycle 100 of a load: all outputs 0 asynchronously, no done. A fresh load afterwards completes normally with correct data.
